fifo_umbral: RTL and testbench

//   Synchronous FIFO with threshold flags, one instance per switch queue (MF, VC, D).

---
 rtl/fifo_umbral_pkg.sv | 22 ++
 rtl/fifo_umbral_ram_dp.sv | 38 +++
 rtl/fifo_umbral.sv | 87 ++++++++
 tb/tb_fifo_umbral.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_umbral_pkg.sv
// Shared constants for the switch-queue FIFOs: default geometry, depth helper
// and the bit positions of each queue inside the FIFO_empties/FIFO_errors buses.
package fifo_umbral_pkg;

    localparam int DATA_WIDTH_DEF = 6;
    localparam int ADDR_WIDTH_DEF = 2;

    localparam int FIFO_FLAGS_W = 5;

    typedef enum int {
        FLAG_IDX_MF0 = 0,
        FLAG_IDX_MF1 = 1,
        FLAG_IDX_VC0 = 2,
        FLAG_IDX_VC1 = 3,
        FLAG_IDX_D   = 4
    } flag_idx_e;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/fifo_umbral_ram_dp.sv
// DEPTH x DATA_WIDTH storage with one write port and one registered read port.
// Only the read register is reset; the array itself keeps its contents.
module ram_dp
    import fifo_umbral_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read-before-write on a shared address: a pop from a full FIFO sees the old word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_umbral.sv
// Synchronous FIFO with almost-full/almost-empty thresholds and a sticky
// overflow/underflow error, one instance per switch queue.
module fifo_umbral
    import fifo_umbral_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-1:0] Umbral_alto,
    input  logic [ADDR_WIDTH-1:0] Umbral_bajo,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  error
);

    localparam int                DEPTH   = fifo_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] COUNT_MAX = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  push_ok;
    logic                  pop_ok;
    logic                  overflow;
    logic                  underflow;

    assign empty        = (count == '0);
    assign full         = (count == COUNT_MAX);
    assign almost_full  = (Umbral_alto != '0) && (count >= {1'b0, Umbral_alto});
    assign almost_empty = (count <= {1'b0, Umbral_bajo});

    // A full FIFO still takes a push when the same edge frees a slot.
    assign push_ok   = push && (!full || pop);
    assign pop_ok    = pop && !empty;
    assign overflow  = push && full && !pop;
    assign underflow = pop && empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            valid_out <= 1'b0;
            error     <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            valid_out <= pop_ok;
            if (overflow || underflow) begin
                error <= 1'b1;
            end
        end
    end

    ram_dp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (pop_ok),
        .rd_addr (rd_ptr),
        .rd_data (data_out)
    );

endmodule

// File: tb/tb_fifo_umbral.sv
// Directed bench for fifo_umbral: reset values, thresholds, overflow,
// push-while-full, underflow with push, pointer wrap and mid-transfer reset.
module tb_fifo_umbral;

    logic       clk;
    logic       reset;
    logic       push;
    logic [5:0] data_in;
    logic       pop;
    logic [1:0] Umbral_alto;
    logic [1:0] Umbral_bajo;
    logic [5:0] data_out;
    logic       valid_out;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic       almost_empty;
    logic       error;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_umbral #(
        .DATA_WIDTH (6),
        .ADDR_WIDTH (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .Umbral_alto  (Umbral_alto),
        .Umbral_bajo  (Umbral_bajo),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic ps, input logic [5:0] d, input logic pp);
        @(negedge clk);
        push    = ps;
        data_in = d;
        pop     = pp;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_empty"},   32'(empty),        32'd1);
        check_val({tag, "_full"},    32'(full),         32'd0);
        check_val({tag, "_aempty"},  32'(almost_empty), 32'd1);
        check_val({tag, "_afull"},   32'(almost_full),  32'd0);
        check_val({tag, "_valid"},   32'(valid_out),    32'd0);
        check_val({tag, "_error"},   32'(error),        32'd0);
        check_val({tag, "_dout"},    32'(data_out),     32'd0);
    endtask

    // Assert reset between edges and check outputs before any clock edge arrives.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals(tag);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset       = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        data_in     = '0;
        Umbral_alto = 2'd3;
        Umbral_bajo = 2'd1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("por");
        @(negedge clk);
        reset = 1'b1;

        // Thresholds and read latency
        step(1'b1, 6'h11, 1'b0);
        check_val("t2_ae_after1", 32'(almost_empty), 32'd1);
        check_val("t2_af_after1", 32'(almost_full),  32'd0);
        step(1'b1, 6'h22, 1'b0);
        check_val("t2_ae_after2", 32'(almost_empty), 32'd0);
        check_val("t2_af_after2", 32'(almost_full),  32'd0);
        step(1'b1, 6'h33, 1'b0);
        check_val("t2_af_after3", 32'(almost_full),  32'd1);
        check_val("t2_full3",     32'(full),         32'd0);
        step(1'b0, 6'h00, 1'b1);
        check_val("t2_valid1", 32'(valid_out), 32'd1);
        check_val("t2_dout1",  32'(data_out),  32'h11);
        check_val("t2_af_pop1", 32'(almost_full), 32'd0);
        step(1'b0, 6'h00, 1'b1);
        check_val("t2_dout2",  32'(data_out),  32'h22);
        check_val("t2_ae_pop2", 32'(almost_empty), 32'd1);
        step(1'b0, 6'h00, 1'b1);
        check_val("t2_dout3",  32'(data_out),  32'h33);
        check_val("t2_empty",  32'(empty),     32'd1);
        step(1'b0, 6'h00, 1'b0);
        check_val("t2_valid_idle", 32'(valid_out), 32'd0);
        check_val("t2_dout_hold",  32'(data_out),  32'h33);
        check_val("t2_error",      32'(error),     32'd0);

        // Overflow drops the word
        for (int i = 1; i <= 4; i++) step(1'b1, 6'(i), 1'b0);
        check_val("t3_full", 32'(full), 32'd1);
        check_val("t3_err_before", 32'(error), 32'd0);
        step(1'b1, 6'h3F, 1'b0);
        check_val("t3_full_ovf", 32'(full),  32'd1);
        check_val("t3_err_ovf",  32'(error), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 6'h00, 1'b1);
            check_val($sformatf("t3_dout%0d", i), 32'(data_out), 32'(i));
        end
        check_val("t3_empty", 32'(empty), 32'd1);
        check_val("t3_err_sticky", 32'(error), 32'd1);

        // Push and pop together on a full FIFO
        async_reset("t4_rst");
        for (int i = 1; i <= 4; i++) step(1'b1, 6'(6'h20 + i), 1'b0);
        step(1'b1, 6'h05, 1'b1);
        check_val("t4_full",  32'(full),      32'd1);
        check_val("t4_valid", 32'(valid_out), 32'd1);
        check_val("t4_dout",  32'(data_out),  32'h21);
        check_val("t4_error", 32'(error),     32'd0);
        step(1'b0, 6'h00, 1'b1);
        check_val("t4_dout2", 32'(data_out), 32'h22);
        step(1'b0, 6'h00, 1'b1);
        check_val("t4_dout3", 32'(data_out), 32'h23);
        step(1'b0, 6'h00, 1'b1);
        check_val("t4_dout4", 32'(data_out), 32'h24);
        step(1'b0, 6'h00, 1'b1);
        check_val("t4_dout5", 32'(data_out), 32'h05);
        check_val("t4_empty", 32'(empty),    32'd1);

        // Underflow with a simultaneous push
        async_reset("t5_rst");
        step(1'b1, 6'h0A, 1'b1);
        check_val("t5_error", 32'(error),     32'd1);
        check_val("t5_valid", 32'(valid_out), 32'd0);
        check_val("t5_empty", 32'(empty),     32'd0);
        check_val("t5_ae",    32'(almost_empty), 32'd1);
        step(1'b0, 6'h00, 1'b1);
        check_val("t5_dout",  32'(data_out),  32'h0A);
        check_val("t5_valid2", 32'(valid_out), 32'd1);
        check_val("t5_empty2", 32'(empty),     32'd1);

        // Nine words streamed through, pointers wrap twice
        async_reset("t6_rst");
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 6'(6'h10 + i), i >= 2);
            if (i >= 2) begin
                check_val($sformatf("t6_dout%0d", i - 2), 32'(data_out), 32'(6'h10 + i - 2));
            end
        end
        for (int i = 7; i < 9; i++) begin
            step(1'b0, 6'h00, 1'b1);
            check_val($sformatf("t6_dout%0d", i), 32'(data_out), 32'(6'h10 + i));
        end
        check_val("t6_empty", 32'(empty), 32'd1);
        check_val("t6_error", 32'(error), 32'd0);

        // Reset in the middle of a transfer discards contents
        step(1'b1, 6'h2A, 1'b0);
        step(1'b1, 6'h2B, 1'b0);
        step(1'b0, 6'h00, 1'b1);
        check_val("t1_dout_pre", 32'(data_out), 32'h2A);
        async_reset("t1_mid");
        step(1'b1, 6'h15, 1'b0);
        step(1'b0, 6'h00, 1'b1);
        check_val("t1_dout_post",  32'(data_out), 32'h15);
        check_val("t1_empty_post", 32'(empty),    32'd1);
        check_val("t1_error_post", 32'(error),    32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
